// File: rtl/exp3_pkg.sv
// rtl/exp3_pkg.sv - state encoding, output bundle and defaults for the exp3 control unit
package exp3_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  function automatic saidas_t saidas_de(input estado_t estado);
    saidas_t s;
    s = '0;
    case (estado)
      PREPARA:    begin s.zera_c = 1'b1; s.zera_r = 1'b1; end
      REGISTRA:   s.registra_r = 1'b1;
      PROXIMO:    s.conta_c = 1'b1;
      FIM_ACERTO: begin s.pronto = 1'b1; s.acertou = 1'b1; end
      FIM_ERRO:   begin s.pronto = 1'b1; s.errou = 1'b1; end
`ifdef EXP3_UC_TIMEOUT_EN
      FIM_TIMEOUT: begin s.pronto = 1'b1; s.errou = 1'b1; s.timeout = 1'b1; end
`endif
      default:    s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - one-cycle pulse on each 0->1 transition of sinal
module edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q, sinal_d;

  always_comb sinal_d = sinal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sinal_q <= 1'b0;
    else          sinal_q <= sinal_d;
  end

  assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/exp3_unidade_controle.sv
// rtl/exp3_unidade_controle.sv - Moore controller for the exp3 memory game; EXP3_UC_TIMEOUT_EN adds the ESPERA timeout
module exp3_unidade_controle
  import exp3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic [3:0] db_estado,
  output logic       db_timeout
);

  estado_t estado_q, estado_d;
  saidas_t saidas_q, saidas_d;
  logic    jogada_pulse;

  edge_detector u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sinal   (jogada),
    .pulso   (jogada_pulse)
  );

`ifdef EXP3_UC_TIMEOUT_EN
  localparam logic [15:0] TIMER_ULTIMO = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer_q, timer_d;
  logic        timer_fim;

  assign timer_fim = (timer_q == TIMER_ULTIMO);

  // Counts only while staying in ESPERA, so it reads 0 in every other state.
  always_comb begin
    timer_d = '0;
    if (estado_q == ESPERA && estado_d == ESPERA) timer_d = timer_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) timer_q <= '0;
    else          timer_q <= timer_d;
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:  if (iniciar) estado_d = PREPARA;
      PREPARA:  estado_d = ESPERA;
`ifdef EXP3_UC_TIMEOUT_EN
      ESPERA: begin
        if (jogada_pulse)   estado_d = REGISTRA;
        else if (timer_fim) estado_d = FIM_TIMEOUT;
      end
      FIM_TIMEOUT: if (iniciar) estado_d = PREPARA;
`else
      ESPERA:   if (jogada_pulse) estado_d = REGISTRA;
`endif
      REGISTRA: estado_d = COMPARA;
      COMPARA: begin
        if (!chavesIgualMemoria) estado_d = FIM_ERRO;
        else if (fimC)           estado_d = FIM_ACERTO;
        else                     estado_d = PROXIMO;
      end
      PROXIMO:    estado_d = ESPERA;
      FIM_ACERTO: if (iniciar) estado_d = PREPARA;
      FIM_ERRO:   if (iniciar) estado_d = PREPARA;
      default:    estado_d = INICIAL;
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    saidas_d = saidas_de(estado_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= INICIAL;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= saidas_d;
    end
  end

  assign zeraC      = saidas_q.zera_c;
  assign contaC     = saidas_q.conta_c;
  assign zeraR      = saidas_q.zera_r;
  assign registraR  = saidas_q.registra_r;
  assign pronto     = saidas_q.pronto;
  assign acertou    = saidas_q.acertou;
  assign errou      = saidas_q.errou;
  assign db_timeout = saidas_q.timeout;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// tb/tb_exp3_unidade_controle.sv - randomized self-checking bench for exp3_unidade_controle with a datapath model
module tb_exp3_unidade_controle;

  localparam logic [3:0] ST_INICIAL  = 4'h0;
  localparam logic [3:0] ST_PREPARA  = 4'h1;
  localparam logic [3:0] ST_ESPERA   = 4'h2;
  localparam logic [3:0] ST_REGISTRA = 4'h4;
  localparam logic [3:0] ST_COMPARA  = 4'h5;
  localparam logic [3:0] ST_PROXIMO  = 4'h6;
  localparam logic [3:0] ST_ACERTO   = 4'hA;
  localparam logic [3:0] ST_TIMEOUT  = 4'hD;
  localparam logic [3:0] ST_ERRO     = 4'hE;
`ifdef EXP3_UC_TIMEOUT_EN
  localparam int HOLD_LONG = 5;
`else
  localparam int HOLD_LONG = 20;
`endif

  logic       clock = 1'b0;
  logic       reset_n, iniciar, jogada;
  logic       chavesIgualMemoria, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_timeout;
  logic [3:0] db_estado;
  logic [7:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

`ifdef EXP3_UC_TIMEOUT_EN
  exp3_unidade_controle #(.TIMEOUT_CYCLES(10)) dut (
`else
  exp3_unidade_controle dut (
`endif
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .jogada(jogada),
    .chavesIgualMemoria(chavesIgualMemoria), .fimC(fimC),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .acertou(acertou), .errou(errou),
    .db_estado(db_estado), .db_timeout(db_timeout)
  );

  assign outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_timeout};

  // Datapath model: address counter, key register and ROM
  logic [3:0] rom [16];
  logic [3:0] chaves;
  logic [3:0] end_q = 4'h0;
  logic [3:0] reg_q = 4'h0;
  int conta_count = 0;
  int reg_count   = 0;

  always @(posedge clock) begin
    if (zeraC)       end_q <= 4'h0;
    else if (contaC) end_q <= end_q + 4'h1;
    if (zeraR)          reg_q <= 4'h0;
    else if (registraR) reg_q <= chaves;
    if (contaC)    conta_count <= conta_count + 1;
    if (registraR) reg_count   <= reg_count + 1;
  end

  assign chavesIgualMemoria = (reg_q == rom[end_q]);
  assign fimC = (end_q == 4'hF);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,db_timeout} per state
  function automatic logic [7:0] exp_outs(input logic [3:0] st);
    case (st)
      ST_PREPARA:  return 8'b1010_0000;
      ST_REGISTRA: return 8'b0001_0000;
      ST_PROXIMO:  return 8'b0100_0000;
      ST_ACERTO:   return 8'b0000_1100;
      ST_ERRO:     return 8'b0000_1010;
      ST_TIMEOUT:  return 8'b0000_1011;
      default:     return 8'b0000_0000;
    endcase
  endfunction

  task automatic expect_state(input string tag, input logic [3:0] st);
    check({tag, "_estado"}, 32'(db_estado), 32'(st));
    check({tag, "_saidas"}, 32'(outs), 32'(exp_outs(st)));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_game;
    iniciar = 1'b1;
    tick;
    expect_state("prepara", ST_PREPARA);
    iniciar = 1'b0;
    tick;
    expect_state("espera", ST_ESPERA);
    check("addr_zero", 32'(end_q), 32'd0);
  endtask

  task automatic play_move(input int i, input logic [3:0] val, input bit jitter,
                           input int hold, output bit fim, output logic [3:0] nxt);
    chaves = val;
    jogada = 1'b1;
    tick;
    expect_state("registra", ST_REGISTRA);
    if (jitter) jogada = 1'b0;
    tick;
    expect_state("compara", ST_COMPARA);
    if (jitter) jogada = 1'b1;
    tick;
    if (val != rom[i]) begin
      nxt = ST_ERRO;
      fim = 1'b1;
    end else if (i == 15) begin
      nxt = ST_ACERTO;
      fim = 1'b1;
    end else begin
      nxt = ST_ESPERA;
      fim = 1'b0;
      expect_state("proximo", ST_PROXIMO);
      tick;
    end
    expect_state("apos_jogada", nxt);
    repeat (hold) begin
      tick;
      expect_state("segura", nxt);
    end
    jogada = 1'b0;
    tick;
    expect_state("solta", nxt);
  endtask

  // wrong_at = 16 means every move is correct
  task automatic play_game(input int wrong_at, input bit iniciar_mid, input int hold_first);
    int c0, r0, hold, exp_moves;
    bit fim, jitter;
    logic [3:0] v, nxt;
    c0 = conta_count;
    r0 = reg_count;
    nxt = ST_ESPERA;
    start_game;
    for (int i = 0; i < 16; i++) begin
      if (iniciar_mid && i == 1) begin
        iniciar = 1'b1;
        repeat (3) begin
          tick;
          expect_state("iniciar_ignorado", ST_ESPERA);
        end
        iniciar = 1'b0;
      end
      v = rom[i];
      if (i == wrong_at) v = rom[i] ^ 4'($urandom_range(1, 15));
      jitter = 1'($urandom_range(0, 1));
      hold = (i == 0) ? hold_first : $urandom_range(0, 3);
      play_move(i, v, jitter, hold, fim, nxt);
      if (fim) break;
    end
    repeat (3) tick;
    expect_state("final", (wrong_at < 16) ? ST_ERRO : ST_ACERTO);
    exp_moves = (wrong_at < 16) ? wrong_at + 1 : 16;
    check("conta_pulsos", 32'(conta_count - c0), 32'(exp_moves - 1));
    check("registra_pulsos", 32'(reg_count - r0), 32'(exp_moves));
    check("addr_final", 32'(end_q), 32'(exp_moves - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fim;
    logic [3:0] nxt;
    reset_n = 1'b0;
    iniciar = 1'b0;
    jogada  = 1'b0;
    chaves  = 4'h0;
    for (int k = 0; k < 16; k++) rom[k] = 4'($urandom);
    tick;
    tick;
    expect_state("reset", ST_INICIAL);
    reset_n = 1'b1;
    tick;
    expect_state("inicial_ocioso", ST_INICIAL);

    play_game(16, 1'b0, 0);
    play_game(2, 1'b0, 0);
    play_game(16, 1'b1, HOLD_LONG);

    // Reset asserted in COMPARA abandons the game immediately
    start_game;
    chaves = rom[0];
    jogada = 1'b1;
    tick;
    expect_state("registra_r", ST_REGISTRA);
    tick;
    expect_state("compara_r", ST_COMPARA);
    reset_n = 1'b0;
    #1;
    expect_state("reset_meio", ST_INICIAL);
    jogada = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    expect_state("apos_reset", ST_INICIAL);

    play_game(0, 1'b0, 1);
    for (int g = 0; g < 6; g++) play_game($urandom_range(0, 16), 1'($urandom_range(0, 1)), $urandom_range(0, 4));

`ifdef EXP3_UC_TIMEOUT_EN
    start_game;
    repeat (9) begin
      tick;
      expect_state("espera_timer", ST_ESPERA);
    end
    tick;
    expect_state("timeout", ST_TIMEOUT);
    start_game;
    repeat (9) begin
      tick;
      expect_state("espera_timer2", ST_ESPERA);
    end
    play_move(0, rom[0], 1'b0, 0, fim, nxt);
    check("pulso_vence_timeout", 32'(db_estado), 32'(nxt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
